// File: rtl/per_bus_master_if.sv
// Bundle of the command/write/read streams and the per-bus for per_bus_master.
// The master modport is the bus initiator's view; slave is the environment's view.
interface per_bus_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_be;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_incr;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_din;
  logic              per_en;
  logic [1:0]        per_we;
  logic [DATA_W-1:0] per_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_len, cmd_incr,
    input  wr_valid, wr_data, rd_ready, per_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    output per_addr, per_din, per_en, per_we
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_len, cmd_incr,
    output wr_valid, wr_data, rd_ready, per_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  per_addr, per_din, per_en, per_we
  );
endinterface

// File: rtl/per_bus_master.sv
// Peripheral-bus initiator: turns single/burst read/write commands into per-bus cycles,
// taking write data from a stream and returning read data on a stream with backpressure.
module per_bus_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4
) (
  input  logic           mclk,
  input  logic           puc_rst,
  per_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_CYC, RD_CYC, RD_HOLD} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;
  logic              incr_q, incr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              per_en_q, per_en_d;
  logic [ADDR_W-1:0] per_addr_q, per_addr_d;
  logic [DATA_W-1:0] per_din_q, per_din_d;
  logic [1:0]        per_we_q, per_we_d;

  logic              last_beat;
  logic [ADDR_W-1:0] addr_step;

  assign last_beat = (remaining_q == '0);
  // Wraps modulo 2^ADDR_W by plain truncation.
  assign addr_step = addr_q + {{(ADDR_W-1){1'b0}}, incr_q};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    be_d        = be_q;
    incr_d      = incr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    done_d      = 1'b0;
    per_din_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          incr_d      = bus.cmd_incr;
          be_d        = (bus.cmd_be == 2'b00) ? 2'b11 : bus.cmd_be;
          state_d     = bus.cmd_write ? WR_WAIT : RD_CYC;
        end
      end
      WR_WAIT: begin
        if (bus.wr_valid) begin
          per_din_d = bus.wr_data;
          state_d   = WR_CYC;
        end
      end
      WR_CYC: begin
        if (!last_beat) begin
          remaining_d = remaining_q - 1'b1;
          addr_d      = addr_step;
          state_d     = WR_WAIT;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_CYC: begin
        rd_data_d  = bus.per_dout;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (!last_beat) begin
            remaining_d = remaining_q - 1'b1;
            addr_d      = addr_step;
            state_d     = RD_CYC;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered copies of what the next state will drive.
    per_en_d   = (state_d == WR_CYC) || (state_d == RD_CYC);
    per_addr_d = per_en_d ? addr_d : '0;
    per_we_d   = (state_d == WR_CYC) ? be_d : 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      incr_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      per_en_q    <= 1'b0;
      per_addr_q  <= '0;
      per_din_q   <= '0;
      per_we_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      incr_q      <= incr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      per_en_q    <= per_en_d;
      per_addr_q  <= per_addr_d;
      per_din_q   <= per_din_d;
      per_we_q    <= per_we_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WR_WAIT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.per_en    = per_en_q;
  assign bus.per_addr  = per_addr_q;
  assign bus.per_din   = per_din_q;
  assign bus.per_we    = per_we_q;

endmodule

// File: tb/tb_per_bus_master.sv
// Bench for per_bus_master: directed scenarios plus random bursts against a word-memory model
// that predicts every per-bus cycle and every read-back value.
module tb_per_bus_master;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int AMASK  = (1 << ADDR_W) - 1;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [1:0]        we;
    logic [DATA_W-1:0] d;
  } bus_t;

  logic mclk = 1'b0;
  logic puc_rst;

  per_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  per_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (bus)
  );

  always #5 mclk = ~mclk;

  logic [DATA_W-1:0] slave_mem [1 << ADDR_W];
  logic [DATA_W-1:0] model_mem [1 << ADDR_W];
  logic [DATA_W-1:0] wdata [16];
  bus_t bus_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   en_viol  = 0;
  bit   mon_on   = 1'b0;
  logic prev_en  = 1'b0;

  // Peripheral slave: combinational read data, byte-strobed writes.
  assign bus.per_dout = slave_mem[bus.per_addr];
  always @(posedge mclk) begin
    if (bus.per_en === 1'b1) begin
      if (bus.per_we[0]) slave_mem[bus.per_addr][7:0]  <= bus.per_din[7:0];
      if (bus.per_we[1]) slave_mem[bus.per_addr][15:8] <= bus.per_din[15:8];
    end
  end

  // Bus monitor: logs every per_en cycle and counts protocol-rule violations.
  always @(negedge mclk) begin
    if (mon_on) begin
      if (bus.per_en) bus_q.push_back('{a: bus.per_addr, we: bus.per_we, d: bus.per_din});
      if (bus.per_en && prev_en) en_viol++;
      if (!bus.per_en && (bus.per_addr != '0 || bus.per_din != '0 || bus.per_we != '0)) en_viol++;
      if (bus.done) done_cnt++;
      prev_en = bus.per_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic model_write(input int a, input logic [1:0] we, input logic [DATA_W-1:0] d);
    if (we[0]) model_mem[a][7:0]  = d[7:0];
    if (we[1]) model_mem[a][15:8] = d[15:8];
  endtask

  task automatic wait_cmd_ready();
    int cnt = 0;
    while (!bus.cmd_ready && cnt < 50) begin step(); cnt++; end
    check("cmd_ready_wait", bus.cmd_ready, 1'b1);
  endtask

  // One full command; for reads, beat stall_beat is stalled for stall_cyc cycles.
  task automatic do_burst(input bit wr, input int addr, input logic [1:0] be, input int len,
                          input bit incr, input int stall_beat, input int stall_cyc);
    int cnt, dc0, stall, base, a;
    logic [1:0] exp_we;
    logic [DATA_W-1:0] held;
    bus_q.delete();
    dc0 = done_cnt;
    exp_we = wr ? ((be == 2'b00) ? 2'b11 : be) : 2'b00;
    wait_cmd_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_be    = be;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_incr  = incr;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ADDR_W'($urandom);
    if (wr) check("wr_ready_lat", bus.wr_ready, 1'b1);
    for (int i = 0; i <= len; i++) begin
      a = (addr + i * int'(incr)) & AMASK;
      if (wr) begin
        repeat ($urandom_range(0, 2)) step();
        bus.wr_data  = wdata[i];
        bus.wr_valid = 1'b1;
        cnt = 0;
        while (!bus.wr_ready && cnt < 20) begin step(); cnt++; end
        check("wr_ready_wait", bus.wr_ready, 1'b1);
        step();
        bus.wr_valid = 1'b0;
        bus.wr_data  = DATA_W'($urandom);
        check("wr_en_lat", bus.per_en, 1'b1);
        model_write(a, exp_we, wdata[i]);
      end else begin
        check("rd_en_lat", bus.per_en, 1'b1);
        step();
        check("rd_valid_lat", bus.rd_valid, 1'b1);
        stall = (i == stall_beat) ? stall_cyc : $urandom_range(0, 2);
        base  = bus_q.size();
        held  = bus.rd_data;
        repeat (stall) step();
        if (stall > 0) begin
          check("rd_hold_data", bus.rd_data, held);
          check("rd_hold_valid", bus.rd_valid, 1'b1);
          check("rd_hold_no_en", bus_q.size(), base);
        end
        check("rd_data", bus.rd_data, model_mem[a]);
        bus.rd_ready = 1'b1;
        step();
        bus.rd_ready = 1'b0;
        check("rd_valid_drop", bus.rd_valid, 1'b0);
      end
    end
    cnt = 0;
    while (bus.busy && cnt < 10) begin step(); cnt++; end
    check("idle_reached", bus.busy, 1'b0);
    check("done_at_idle", bus.done, 1'b1);
    step();
    check("done_count", done_cnt - dc0, 1);
    check("n_beats", bus_q.size(), len + 1);
    for (int i = 0; i < bus_q.size() && i <= len; i++) begin
      a = (addr + i * int'(incr)) & AMASK;
      check("beat_addr", bus_q[i].a, a);
      check("beat_we", bus_q[i].we, exp_we);
      check("beat_din", bus_q[i].d, wr ? wdata[i] : '0);
    end
  endtask

  initial begin
    int dc0, len, addr;
    bit wr;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      slave_mem[i] = '0;
      model_mem[i] = '0;
    end
    puc_rst       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_be    = '0;
    bus.cmd_len   = '0;
    bus.cmd_incr  = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_wr_ready", bus.wr_ready, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data", bus.rd_data, '0);
    check("rst_per", {bus.per_en, bus.per_we, bus.per_addr, bus.per_din}, '0);
    puc_rst = 1'b0;
    mon_on  = 1'b1;
    step();

    // Single write then read-back
    wdata[0] = 16'hBEEF;
    do_burst(1'b1, 'h088, 2'b11, 0, 1'b1, -1, 0);
    do_burst(1'b0, 'h088, 2'b00, 0, 1'b1, -1, 0);

    // Incrementing read burst with a 3-cycle stall on beat 2
    do_burst(1'b0, 'h088, 2'b00, 2, 1'b1, 1, 3);

    // wr_valid while idle must not start anything
    bus_q.delete();
    bus.wr_valid = 1'b1;
    repeat (3) step();
    bus.wr_valid = 1'b0;
    check("idle_wr_ignored", bus_q.size(), 0);
    check("idle_still_idle", bus.busy, 1'b0);

    // Byte-enable promotion and partial write, then read-back of the merge
    wdata[0] = 16'h0055;
    do_burst(1'b1, 'h089, 2'b00, 0, 1'b1, -1, 0);
    wdata[0] = 16'hA5C3;
    do_burst(1'b1, 'h089, 2'b10, 0, 1'b1, -1, 0);
    do_burst(1'b0, 'h089, 2'b00, 0, 1'b1, -1, 0);

    // Address wrap and fixed address
    do_burst(1'b0, 'h3FFF, 2'b00, 1, 1'b1, -1, 0);
    do_burst(1'b0, 'h3FFF, 2'b00, 1, 1'b0, -1, 0);

    // Random bursts
    for (int n = 0; n < 30; n++) begin
      wr   = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 15);
      addr = ($urandom_range(0, 3) == 0) ? ('h3FF0 + $urandom_range(0, 15)) : $urandom_range(0, 'hFF);
      for (int i = 0; i < 16; i++) wdata[i] = DATA_W'($urandom);
      do_burst(wr, addr, 2'($urandom_range(0, 3)), len, 1'($urandom_range(0, 1)), -1, 0);
    end

    // Reset in the middle of a 4-beat write
    bus_q.delete();
    dc0 = done_cnt;
    wait_cmd_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 'h100;
    bus.cmd_be    = 2'b11;
    bus.cmd_len   = 4'd3;
    bus.cmd_incr  = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.wr_data   = 16'h1234;
    bus.wr_valid  = 1'b1;
    step();
    bus.wr_valid  = 1'b0;
    check("abort_beat1_en", bus.per_en, 1'b1);
    step();
    puc_rst = 1'b1;
    step();
    puc_rst = 1'b0;
    check("abort_per_en", bus.per_en, 1'b0);
    check("abort_rd_valid", bus.rd_valid, 1'b0);
    check("abort_cmd_ready", bus.cmd_ready, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    bus.wr_valid = 1'b1;
    repeat (6) step();
    bus.wr_valid = 1'b0;
    check("abort_beats", bus_q.size(), 1);
    check("abort_no_done", done_cnt - dc0, 0);
    model_write('h100, 2'b11, 16'h1234);
    do_burst(1'b0, 'h100, 2'b00, 1, 1'b1, -1, 0);

    check("per_en_rules", en_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
